// File: rtl/data_bus_ctrl_pkg.sv
// Shared constants for the CPU core: opcodes, branch conditions, data-bus FSM
// states and byte-lane selectors.
// Latency: n/a (declarations only). Backpressure: n/a.
package data_bus_ctrl_pkg;

  // Opcode and branch-condition encodings used by the decoder.
  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_LB   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_SB   = 4'hB;
  localparam logic [3:0] OP_BR   = 4'hC;

  localparam logic [1:0] BR_EQ   = 2'd0;
  localparam logic [1:0] BR_NE   = 2'd1;
  localparam logic [1:0] BR_LT   = 2'd2;
  localparam logic [1:0] BR_AL   = 2'd3;

  // Data-bus responder states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RAM_RD   = 2'd1,
    ST_PER_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } bus_state_t;

  // Big-endian lane select taken from addr[0].
  localparam logic LANE_HI = 1'b0;  // bits [15:8]
  localparam logic LANE_LO = 1'b1;  // bits [7:0]

endpackage

// File: rtl/data_bus_ctrl_byte_lane_unit.sv
// Byte-lane steering: store replication/enables and load byte select/zero-extend.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Ports: st_* = store-side request -> st_data/st_be; ld_* = load-side raw word -> ld_data.
module byte_lane_unit
  import data_bus_ctrl_pkg::*;
(
  input  logic        st_byte,
  input  logic        st_lane,
  input  logic [15:0] st_wdata,
  output logic [15:0] st_data,
  output logic [1:0]  st_be,
  input  logic        ld_byte,
  input  logic        ld_lane,
  input  logic [15:0] ld_raw,
  output logic [15:0] ld_data
);

  always_comb begin
    st_data = st_wdata;
    st_be   = 2'b11;
    if (st_byte) begin
      // Byte stores drive the byte on both lanes; only the enable selects.
      st_data = {st_wdata[7:0], st_wdata[7:0]};
      st_be   = (st_lane == LANE_HI) ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ld_data = ld_raw;
    if (ld_byte) begin
      ld_data = (ld_lane == LANE_HI) ? {8'h00, ld_raw[15:8]} : {8'h00, ld_raw[7:0]};
    end
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// CPU data-memory responder: routes lw/lb/sw/sb to sync RAM or peripheral bus.
// Latency: RAM store 0, RAM load 1, peripheral ack cycle + 1 (timeout TIMEOUT+1).
// Backpressure: CPU holds request until o_rdy; peripheral stalls via i_per_ack.
// Ports: i_lw/i_lb/i_sw/i_sb/i_addr/i_wdata request, o_rdy/o_rdata/o_bus_err response,
//        o_ram_* / i_ram_rdata RAM side, o_per_* / i_per_rdata / i_per_ack peripheral side.
module data_bus_ctrl
  import data_bus_ctrl_pkg::*;
#(
  parameter logic [7:0] PER_PAGE = 8'hFF,
  parameter int         TIMEOUT  = 16,
  parameter int         CNT_W    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lw,
  input  logic        i_lb,
  input  logic        i_sw,
  input  logic        i_sb,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic        o_rdy,
  output logic [15:0] o_rdata,
  output logic        o_bus_err,
  output logic        o_ram_en,
  output logic [1:0]  o_ram_we,
  output logic [14:0] o_ram_addr,
  output logic [15:0] o_ram_wdata,
  input  logic [15:0] i_ram_rdata,
  output logic        o_per_sel,
  output logic        o_per_we,
  output logic [1:0]  o_per_be,
  output logic [7:0]  o_per_addr,
  output logic [15:0] o_per_wdata,
  input  logic [15:0] i_per_rdata,
  input  logic        i_per_ack
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  bus_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      cap_data;
  logic             err_flag;
  logic             op_ld;
  logic             op_byte;
  logic             op_lane;

  // Request decode with lw > lb > sw > sb precedence.
  logic req, req_ld, req_byte, req_per;
  assign req      = i_lw | i_lb | i_sw | i_sb;
  assign req_ld   = i_lw | i_lb;
  assign req_byte = ~i_lw & (i_lb | (~i_sw & i_sb));
  assign req_per  = (i_addr[15:8] == PER_PAGE);

  // Launch only from IDLE; held-off while reset is asserted so a request the
  // CPU still presents during reset cannot leak onto either bus.
  logic launch, ram_launch, per_launch;
  assign launch     = (state == ST_IDLE) && req && !i_rst;
  assign ram_launch = launch && !req_per;
  assign per_launch = launch && req_per;

  logic [15:0] st_data, ld_data, ld_raw;
  logic [1:0]  st_be;

  assign ld_raw = (state == ST_RAM_RD) ? i_ram_rdata : cap_data;

  byte_lane_unit u_lane (
    .st_byte  (req_byte),
    .st_lane  (i_addr[0]),
    .st_wdata (i_wdata),
    .st_data  (st_data),
    .st_be    (st_be),
    .ld_byte  (op_byte),
    .ld_lane  (op_lane),
    .ld_raw   (ld_raw),
    .ld_data  (ld_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cap_data <= '0;
      err_flag <= 1'b0;
      op_ld    <= 1'b0;
      op_byte  <= 1'b0;
      op_lane  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (launch) begin
            op_ld    <= req_ld;
            op_byte  <= req_byte;
            op_lane  <= i_addr[0];
            err_flag <= 1'b0;
            cnt      <= '0;
            if (req_per) begin
              // Zero-wait peripherals may ack in the select cycle.
              if (i_per_ack) begin
                cap_data <= i_per_rdata;
                state    <= ST_DONE;
              end else begin
                state    <= ST_PER_WAIT;
              end
            end else if (req_ld) begin
              state <= ST_RAM_RD;
            end
          end
        end
        ST_RAM_RD: state <= ST_IDLE;
        ST_PER_WAIT: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (i_per_ack) begin
            cap_data <= i_per_rdata;
            state    <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            cap_data <= '0;
            err_flag <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          err_flag <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM side: only driven in the launch cycle.
  assign o_ram_en    = ram_launch;
  assign o_ram_we    = (ram_launch && !req_ld) ? st_be : 2'b00;
  assign o_ram_addr  = ram_launch ? i_addr[15:1] : 15'd0;
  assign o_ram_wdata = (ram_launch && !req_ld) ? st_data : 16'd0;

  // Peripheral side: request fields follow the held CPU request while selected.
  assign o_per_sel   = per_launch || (state == ST_PER_WAIT);
  assign o_per_we    = o_per_sel && !req_ld;
  assign o_per_be    = o_per_sel ? st_be : 2'b00;
  assign o_per_addr  = o_per_sel ? i_addr[7:0] : 8'd0;
  assign o_per_wdata = o_per_sel ? st_data : 16'd0;

  // Response.
  assign o_rdy     = (ram_launch && !req_ld) || (state == ST_RAM_RD) || (state == ST_DONE);
  assign o_rdata   = ((state == ST_RAM_RD) || ((state == ST_DONE) && op_ld)) ? ld_data : 16'd0;
  assign o_bus_err = (state == ST_DONE) && err_flag;

endmodule
